// File: rtl/qbus_slave_mem.sv
// Q-bus responder: word RAM window, one CSR with interrupt request, IAKO daisy chain.
// Define QSLV_BYTE_EN to honour WTBT byte writes; otherwise every write stores a full word.
module qbus_slave_mem #(
  parameter logic [15:0] MEM_BASE = 16'o000000,
  parameter int          MEM_AW   = 10,
  parameter logic [15:0] CSR_ADDR = 16'o177560,
  parameter logic [15:0] IRQ_VEC  = 16'o000060,
  parameter int          RPLY_DLY = 2
) (
  input  logic        pin_clk_p,
  input  logic        pin_rst,
  input  logic [15:0] pin_dal_in,
  output logic [15:0] pin_dal_out,
  output logic        pin_dal_oe,
  input  logic        pin_sync,
  input  logic        pin_din,
  input  logic        pin_dout,
  input  logic        pin_wtbt,
  output logic        pin_rply,
  input  logic        pin_iako_in,
  output logic        pin_iako_out,
  output logic        pin_irq,
  input  logic        pin_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADR, S_RWAIT, S_RRPLY, S_WWAIT, S_WRPLY, S_IWAIT, S_IRPLY, S_IPASS
  } state_t;

  localparam logic [3:0]  DLY    = 4'(RPLY_DLY);
  localparam logic [16:0] MEM_LO = {1'b0, MEM_BASE};
  localparam logic [16:0] MEM_HI = MEM_LO + (17'd2 << MEM_AW);

  state_t              state, state_nx;
  logic                sync_q;
  logic [3:0]          cnt;
  logic [MEM_AW:0]     adr;
  logic [MEM_AW-1:0]   widx;
  logic                sel_mem, sel_csr;
  logic                csr_done, csr_ie;
  logic [15:0]         csr_word;
  logic [15:0]         rdata;
  logic [15:0]         mem [2**MEM_AW];

  logic sync_rise, bus_idle, cnt_hit, hit_mem, hit_csr, irq;
  logic wr_stb, csr_ie_we, csr_rd_exit, in_wait;

  assign sync_rise   = pin_sync & ~sync_q;
  assign bus_idle    = ~pin_sync & ~pin_din & ~pin_dout;
  assign cnt_hit     = (cnt == DLY);
  assign hit_mem     = ({1'b0, pin_dal_in} >= MEM_LO) && ({1'b0, pin_dal_in} < MEM_HI);
  assign hit_csr     = (pin_dal_in[15:1] == CSR_ADDR[15:1]);
  assign irq         = csr_ie & csr_done;
  assign widx        = adr[MEM_AW:1];
  assign csr_word    = {8'b0, csr_done, csr_ie, 6'b0};
  // The write lands on the first WWAIT cycle, while the master still holds data on DAL.
  assign wr_stb      = (state == S_WWAIT) && (cnt == 4'd0);
  assign csr_rd_exit = (state == S_RRPLY) && !pin_din && sel_csr;
  assign in_wait     = (state == S_RWAIT) || (state == S_WWAIT) || (state == S_IWAIT);

`ifdef QSLV_BYTE_EN
  assign csr_ie_we = wr_stb & sel_csr & ~(pin_wtbt & adr[0]);
`else
  logic unused_byte_bits;
  assign unused_byte_bits = ^{pin_wtbt, adr[0]};
  assign csr_ie_we = wr_stb & sel_csr;
`endif

  always_comb begin
    state_nx     = state;
    pin_rply     = 1'b0;
    pin_dal_oe   = 1'b0;
    pin_dal_out  = 16'h0000;
    pin_iako_out = 1'b0;
    pin_irq      = irq;
    case (state)
      S_IDLE: begin
        if (sync_rise && (hit_mem || hit_csr)) begin
          state_nx = S_ADR;
        end else if (!pin_sync && pin_din && pin_iako_in) begin
          state_nx = irq ? S_IWAIT : S_IPASS;
        end
        // Pass IAKO through immediately when the chain reaches us with nothing pending.
        pin_iako_out = ~pin_rst & pin_iako_in & ~pin_sync & pin_din & ~irq;
      end
      S_ADR: begin
        if (pin_din)       state_nx = S_RWAIT;
        else if (pin_dout) state_nx = S_WWAIT;
        else if (bus_idle) state_nx = S_IDLE;
      end
      S_RWAIT: begin
        if (bus_idle)     state_nx = S_IDLE;
        else if (cnt_hit) state_nx = S_RRPLY;
      end
      S_WWAIT: begin
        if (bus_idle)     state_nx = S_IDLE;
        else if (cnt_hit) state_nx = S_WRPLY;
      end
      S_IWAIT: begin
        if (bus_idle)     state_nx = S_IDLE;
        else if (cnt_hit) state_nx = S_IRPLY;
      end
      S_RRPLY: begin
        pin_rply    = 1'b1;
        pin_dal_oe  = 1'b1;
        pin_dal_out = rdata;
        if (!pin_din) state_nx = pin_sync ? S_ADR : S_IDLE;
      end
      S_WRPLY: begin
        pin_rply = 1'b1;
        if (!pin_dout) state_nx = pin_sync ? S_ADR : S_IDLE;
      end
      S_IRPLY: begin
        pin_rply    = 1'b1;
        pin_dal_oe  = 1'b1;
        pin_dal_out = rdata;
        if (!pin_din) state_nx = S_IDLE;
      end
      S_IPASS: begin
        pin_iako_out = ~pin_rst & pin_iako_in;
        if (!pin_din) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge pin_clk_p or posedge pin_rst) begin
    if (pin_rst) begin
      state    <= S_IDLE;
      sync_q   <= 1'b0;
      cnt      <= 4'd0;
      sel_mem  <= 1'b0;
      sel_csr  <= 1'b0;
      csr_done <= 1'b0;
      csr_ie   <= 1'b0;
    end else begin
      state  <= state_nx;
      sync_q <= pin_sync;
      cnt    <= (in_wait && state_nx == state) ? cnt + 4'd1 : 4'd0;
      if (state == S_IDLE && sync_rise) begin
        sel_mem <= hit_mem & ~hit_csr;
        sel_csr <= hit_csr;
      end
      if (csr_ie_we) csr_ie <= pin_dal_in[6];
      // A DONE event coinciding with the read-clear must not be lost.
      if (pin_done)         csr_done <= 1'b1;
      else if (csr_rd_exit) csr_done <= 1'b0;
    end
  end

  always_ff @(posedge pin_clk_p) begin
    if (state == S_IDLE && sync_rise) adr <= pin_dal_in[MEM_AW:0];
    if (wr_stb && sel_mem) begin
`ifdef QSLV_BYTE_EN
      if (pin_wtbt && adr[0])  mem[widx][15:8] <= pin_dal_in[15:8];
      else if (pin_wtbt)       mem[widx][7:0]  <= pin_dal_in[7:0];
      else                     mem[widx]       <= pin_dal_in;
`else
      mem[widx] <= pin_dal_in;
`endif
    end
    case (state)
      S_RWAIT: rdata <= sel_csr ? csr_word : mem[widx];
      S_IWAIT: rdata <= IRQ_VEC;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_qbus_slave_mem.sv
// Bench for qbus_slave_mem: directed bus cycles, replies checked by a scoreboard monitor.
module tb_qbus_slave_mem;
  localparam int RPLY_DLY = 2;
  localparam logic [15:0] CSR = 16'o177560;
`ifdef QSLV_BYTE_EN
  localparam logic [15:0] EXP_HIB = 16'hAB34;
  localparam logic [15:0] EXP_LOB = 16'hABCD;
`else
  localparam logic [15:0] EXP_HIB = 16'hAB00;
  localparam logic [15:0] EXP_LOB = 16'h00CD;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] dal_in = '0, dal_out;
  logic dal_oe, sync = 0, din = 0, dout = 0, wtbt = 0, rply;
  logic iako_in = 0, iako_out, irq, done = 0;

  typedef struct { logic oe; logic [15:0] data; } exp_t;
  exp_t sbq[$];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  qbus_slave_mem #(.RPLY_DLY(RPLY_DLY)) dut (
    .pin_clk_p(clk), .pin_rst(rst), .pin_dal_in(dal_in), .pin_dal_out(dal_out),
    .pin_dal_oe(dal_oe), .pin_sync(sync), .pin_din(din), .pin_dout(dout),
    .pin_wtbt(wtbt), .pin_rply(rply), .pin_iako_in(iako_in), .pin_iako_out(iako_out),
    .pin_irq(irq), .pin_done(done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic oe, input logic [15:0] data);
    exp_t e;
    e.oe = oe;
    e.data = data;
    sbq.push_back(e);
  endtask

  // Monitor: every rising RPLY consumes one scoreboard entry.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rply && !prev) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rply: got rply=1 dal_out=%h, expected no reply", dal_out);
        end else begin
          e = sbq.pop_front();
          check("rply_oe", {31'b0, dal_oe}, {31'b0, e.oe});
          if (e.oe) check("rply_data", {16'b0, dal_out}, {16'b0, e.data});
        end
      end
      prev = rply;
    end
  end

  task automatic wait_rply(input logic lvl, output int cyc);
    bit got;
    got = 0;
    cyc = 0;
    while (!got && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (rply === lvl) got = 1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL rply_timeout: got rply=%b, expected %b within 64 cycles", rply, lvl);
    end
  endtask

  task automatic addr_phase(input logic [15:0] a, input logic w);
    @(posedge clk); #1;
    dal_in = a; wtbt = w; sync = 1;
  endtask

  task automatic data_write(input logic [15:0] d, input logic bw, output int cyc);
    int c2;
    @(posedge clk); #1;
    dal_in = d; wtbt = bw; dout = 1;
    wait_rply(1'b1, cyc);
    @(posedge clk); #1;
    dout = 0;
    wait_rply(1'b0, c2);
  endtask

  task automatic data_read(input logic done_at_exit);
    int c;
    @(posedge clk); #1;
    dal_in = '0; wtbt = 0; din = 1;
    wait_rply(1'b1, c);
    @(posedge clk); #1;
    check("read_hold", {30'b0, rply, dal_oe}, 32'd3);
    din = 0; done = done_at_exit;
    wait_rply(1'b0, c);
    done = 0;
  endtask

  task automatic end_cycle();
    @(posedge clk); #1;
    sync = 0; dal_in = '0; wtbt = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic bw,
                          output int cyc);
    push(1'b0, 16'h0000);
    addr_phase(a, 1'b1);
    data_write(d, bw, cyc);
    end_cycle();
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] exp_d, input logic done_at_exit);
    push(1'b1, exp_d);
    addr_phase(a, 1'b0);
    data_read(done_at_exit);
    end_cycle();
  endtask

  task automatic no_reply(input string name, input logic [15:0] a, input int n);
    bit bad;
    bad = 0;
    addr_phase(a, 1'b0);
    @(posedge clk); #1;
    din = 1;
    repeat (n) begin
      @(posedge clk); #1;
      if (rply || dal_oe) bad = 1;
    end
    check(name, {31'b0, bad}, 32'd0);
    din = 0;
    end_cycle();
  endtask

  initial begin
    int cyc;
    bit bad;
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit bad;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {28'b0, rply, dal_oe, irq, iako_out}, 32'd0);
    check("reset_dal", {16'b0, dal_out}, 32'd0);
    rst = 0;

    // Word write then read back; dout is sampled on the first edge after it is driven.
    do_write(16'o000100, 16'h1234, 1'b0, cyc);
    check("dato_latency", cyc, RPLY_DLY + 2);
    do_read(16'o000100, 16'h1234, 1'b0);

    do_write(16'o000101, 16'hAB00, 1'b1, cyc);
    do_read(16'o000100, EXP_HIB, 1'b0);
    do_write(16'o000100, 16'h00CD, 1'b1, cyc);
    do_read(16'o000100, EXP_LOB, 1'b0);

    do_write(16'o003776, 16'hBEEF, 1'b0, cyc);
    do_read(16'o003776, 16'hBEEF, 1'b0);
    no_reply("unsel_160000", 16'o160000, 50);
    no_reply("unsel_004000", 16'o004000, 20);

    // DATIO: read then write inside one SYNC.
    do_write(16'o000010, 16'h0F0F, 1'b0, cyc);
    push(1'b1, 16'h0F0F);
    push(1'b0, 16'h0000);
    addr_phase(16'o000010, 1'b0);
    data_read(1'b0);
    data_write(16'h5555, 1'b0, cyc);
    end_cycle();
    do_read(16'o000010, 16'h5555, 1'b0);

    // Interrupt path.
    do_write(CSR, 16'o000100, 1'b0, cyc);
    check("irq_ie_only", {31'b0, irq}, 32'd0);
    @(posedge clk); #1; done = 1;
    @(posedge clk); #1; done = 0;
    check("irq_set", {31'b0, irq}, 32'd1);

    push(1'b1, 16'o000060);
    din = 1; iako_in = 1;
    wait_rply(1'b1, cyc);
    check("iak_iako_out", {31'b0, iako_out}, 32'd0);
    @(posedge clk); #1;
    din = 0; iako_in = 0;
    wait_rply(1'b0, cyc);
    @(posedge clk); #1;

    do_read(CSR, 16'o000300, 1'b0);
    check("irq_after_read", {31'b0, irq}, 32'd0);
    do_read(CSR, 16'o000100, 1'b0);

    din = 1; iako_in = 1;
    @(posedge clk); #1;
    check("iak_pass", {31'b0, iako_out}, 32'd1);
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rply) bad = 1;
    end
    check("iak_pass_norply", {31'b0, bad}, 32'd0);
    din = 0; iako_in = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // DONE set coinciding with the read-clear edge.
    done = 1;
    @(posedge clk); #1; done = 0;
    do_read(CSR, 16'o000300, 1'b1);
    check("done_set_wins", {31'b0, irq}, 32'd1);

    // Asynchronous reset in the middle of a read reply.
    push(1'b1, EXP_LOB);
    addr_phase(16'o000100, 1'b0);
    @(posedge clk); #1;
    din = 1;
    wait_rply(1'b1, cyc);
    #6;
    rst = 1;
    #1;
    check("midreset_ctrl", {29'b0, rply, dal_oe, irq}, 32'd0);
    check("midreset_dal", {16'b0, dal_out}, 32'd0);
    din = 0; sync = 0;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    do_read(16'o000100, EXP_LOB, 1'b0);
    do_write(CSR, 16'o000200, 1'b0, cyc);
    do_read(CSR, 16'o000000, 1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_drain", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/qbus_slave_mem.md
Name: qbus_slave_mem

Overview:
- Q-bus target (responder) for the bus cycles the MCP-1621 control chip initiates: DATI, DATO, DATOB, DATIO(B) and the interrupt-acknowledge cycle.
- Contains a word RAM window, one CSR with an interrupt request, and a daisy-chained IAKO pass-through.
- Sits on the LSI-11 Q-bus model between the processor's bus pins and simulation memory/peripherals.
- Synchronous model for simulation and FPGA; bus lines are sampled on pin_clk_p.

Parameters:
- MEM_BASE, 16'o000000: RAM window base byte address; must be aligned to the window size.
- MEM_AW, 10: RAM word address width; the window is 2**MEM_AW words.
- CSR_ADDR, 16'o177560: CSR byte address.
- IRQ_VEC, 16'o000060: vector returned on interrupt acknowledge.
- RPLY_DLY, 2: clock cycles from DIN/DOUT sampled to RPLY asserted; legal range 0..15.

Ports:
- pin_clk_p, in, 1: clock, rising edge.
- pin_rst, in, 1: reset, asynchronous, active-high.
- pin_dal_in, in, 16: DAL bus, value received.
- pin_dal_out, out, 16: DAL bus, value driven.
- pin_dal_oe, out, 1: DAL output enable.
- pin_sync, in, 1: SYNC, active-high.
- pin_din, in, 1: DIN.
- pin_dout, in, 1: DOUT.
- pin_wtbt, in, 1: WTBT. In the address phase it means a write cycle; in the data phase it means a byte write.
- pin_rply, out, 1: RPLY.
- pin_iako_in, in, 1: IAKO daisy chain, input.
- pin_iako_out, out, 1: IAKO daisy chain, output.
- pin_irq, out, 1: interrupt request (IRQ4).
- pin_done, in, 1: one-cycle pulse that sets CSR bit 7 (DONE).

Behaviour:
- Reset (asynchronous, any state, mid-cycle included):
  - state=IDLE, pin_rply=0, pin_dal_oe=0, pin_dal_out=0, pin_iako_out=0.
  - CSR=0, so pin_irq=0; the select latch is cleared.
  - RAM contents are not reset.
- Address phase, on a pin_sync 0->1 edge:
  - Latch pin_dal_in as adr. Sel_mem = adr in [MEM_BASE, MEM_BASE+2*2**MEM_AW-1]; sel_csr = adr[15:1]==CSR_ADDR[15:1].
  - If neither matches: remain unselected and never drive RPLY or DAL.
- States:
  - IDLE -> ADR on the sync edge when selected.
  - ADR -> RWAIT when pin_din=1; -> WWAIT when pin_dout=1 (pin_din has priority if both are set).
  - RWAIT: counter counts to RPLY_DLY -> RRPLY.
  - RRPLY: pin_dal_out=data, pin_dal_oe=1, pin_rply=1. Stay until pin_din=0, then release rply and oe in the same edge and go to ADR (this is what allows DATIO).
  - WWAIT: at the first cycle the write is performed; counter counts to RPLY_DLY -> WRPLY.
  - WRPLY: pin_rply=1. Hold until pin_dout=0 -> ADR.
  - From any bus state: pin_sync=0 with pin_din=0 and pin_dout=0 -> IDLE.
  - pin_sync dropping while RPLY is asserted: finish the handshake first, then go to IDLE.
- Data rules:
  - RAM word index = adr[MEM_AW:1].
  - Word write: stores pin_dal_in.
  - Byte write (pin_wtbt=1 in the data phase): adr[0]=0 writes [7:0]; adr[0]=1 writes [15:8].
  - CSR: only bits 7 (DONE) and 6 (IE) are implemented; other bits read 0.
  - Writes to bit 7 are ignored.
  - A CSR read clears DONE on the RRPLY exit edge.
  - pin_done=1 sets DONE; if a clear happens in the same cycle, the set wins.
- Interrupt: pin_irq = IE & DONE.
- IAK cycle:
  - Entry: in IDLE with pin_sync=0, pin_din=1 and pin_iako_in=1.
  - If pin_irq=1: go to IWAIT, then count RPLY_DLY -> IRPLY. IRPLY drives IRQ_VEC with oe=1 and rply=1 until pin_din=0. pin_iako_out stays 0.
  - If pin_irq=0: pin_iako_out = pin_iako_in, combinational pass-through; no reply.
  - The irq state is sampled once at entry and does not change within the cycle.
- RPLY_DLY=0: RPLY asserts on the first edge after DIN/DOUT is sampled (1-cycle latency).

Optional Feature:
- Macro: QSLV_BYTE_EN.
- Defined: byte writes follow the data rules above.
- Undefined: pin_wtbt in the data phase is ignored. Every DATO/DATOB writes the full word at adr[MEM_AW:1], and the CSR accepts a full-word write.

Test Plan:
- Reset: assert pin_rst mid-RRPLY -> on the same edge rply=0, oe=0, irq=0, state=IDLE.
- DATO then DATI, MEM_BASE=0, RPLY_DLY=2:
  - Address 16'o000100, dout with data 16'h1234 -> rply 3 clocks after dout.
  - DATI to the same address -> dal_out=16'h1234, oe=1, rply=1 until din drops.
- DATOB: address 16'o000101, wtbt=1, data 16'hAB00 onto a stored 16'h1234 -> a later DATI returns 16'hAB34. With QSLV_BYTE_EN undefined, it returns 16'hAB00.
- Unselected address: DATI to 16'o160000 (MEM_AW=10) -> rply and oe stay 0 for 50 cycles.
- DATIO: one sync with din, then dout 16'h5555 at 16'o000010 -> two rply pulses; a later read returns 16'h5555.
- Interrupt:
  - Write CSR 16'o000100 (IE=1) and pulse pin_done -> irq=1.
  - IAK (din, iako_in=1, sync=0) -> dal_out=16'o000060, rply=1, iako_out=0.
  - Read CSR -> 16'o000300, then DONE=0 and irq=0.
  - A repeated IAK -> iako_out=1, no rply.
